// File: rtl/al4s3b_fpga_onion_intrctrl.sv
// Wishbone-slave interrupt aggregator: latches synchronized sources into W1C
// pending bits, then masks and routes them onto four registered INTR_o lines.
module al4s3b_fpga_onion_intrctrl #(
    parameter int unsigned NUM_SRC            = 16,
    parameter int unsigned ADDRWIDTH          = 10,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic               WBs_CLK_i,
    input  logic               WBs_RST_i,
    input  logic [16:0]        WBs_ADR_i,
    input  logic               WBs_CYC_i,
    input  logic [3:0]         WBs_BYTE_STB_i,
    input  logic               WBs_WE_i,
    input  logic               WBs_STB_i,
    input  logic [31:0]        WBs_DAT_i,
    output logic [31:0]        WBs_DAT_o,
    output logic               WBs_ACK_o,
    input  logic [NUM_SRC-1:0] SRC_i,
    output logic [3:0]         INTR_o
);

    localparam int unsigned RTW = 2 * NUM_SRC;
    localparam int unsigned OFW = ADDRWIDTH - 2;

    localparam logic [OFW-1:0] REG_RAW    = OFW'(0);
    localparam logic [OFW-1:0] REG_STATUS = OFW'(1);
    localparam logic [OFW-1:0] REG_ENABLE = OFW'(2);
    localparam logic [OFW-1:0] REG_MODE   = OFW'(3);
    localparam logic [OFW-1:0] REG_ROUTE  = OFW'(4);
    localparam logic [OFW-1:0] REG_SWSET  = OFW'(5);
    localparam logic [OFW-1:0] REG_INTR   = OFW'(6);

    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [NUM_SRC-1:0] status, enable, mode;
    logic [RTW-1:0]     route;

    logic [OFW-1:0]     offset_c;
    logic               access_c, wr_c, rd_c;
    logic [31:0]        lane_mask_c, wdata_c, rdata_c;
    logic [NUM_SRC-1:0] w1c_clear_c, sw_set_c, hw_set_c, status_next_c;
    logic [3:0]         intr_c;
    logic               unused_adr;

    assign unused_adr  = ^{WBs_ADR_i[16:ADDRWIDTH], WBs_ADR_i[1:0]};
    assign offset_c    = WBs_ADR_i[ADDRWIDTH-1:2];
    assign access_c    = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
    assign wr_c        = access_c & WBs_WE_i;
    assign rd_c        = access_c & ~WBs_WE_i;
    assign lane_mask_c = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                          {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
    assign wdata_c     = WBs_DAT_i & lane_mask_c;

    // Pending-bit update: sets win over a same-edge W1C clear
    always_comb begin
        w1c_clear_c = '0;
        sw_set_c    = '0;
        if (wr_c && offset_c == REG_STATUS) w1c_clear_c = NUM_SRC'(wdata_c);
        if (wr_c && offset_c == REG_SWSET)  sw_set_c    = NUM_SRC'(wdata_c);
        hw_set_c      = (mode & s2 & ~s3) | (~mode & s2);
        status_next_c = (status & ~w1c_clear_c) | hw_set_c | sw_set_c;
    end

    always_comb begin
        intr_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (status[i] && enable[i]) intr_c = intr_c | (4'b0001 << route[2*i +: 2]);
        end
    end

    always_comb begin
        rdata_c = DEFAULT_READ_VALUE;
        case (offset_c)
            REG_RAW:    rdata_c = 32'(s2);
            REG_STATUS: rdata_c = 32'(status);
            REG_ENABLE: rdata_c = 32'(enable);
            REG_MODE:   rdata_c = 32'(mode);
            REG_ROUTE:  rdata_c = 32'(route);
            REG_SWSET:  rdata_c = 32'd0;
            REG_INTR:   rdata_c = 32'(INTR_o);
            default:    rdata_c = DEFAULT_READ_VALUE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            status    <= '0;
            enable    <= '0;
            mode      <= '0;
            route     <= '0;
            INTR_o    <= '0;
            WBs_ACK_o <= 1'b0;
            WBs_DAT_o <= '0;
        end else begin
            s1        <= SRC_i;
            s2        <= s1;
            s3        <= s2;
            status    <= status_next_c;
            INTR_o    <= intr_c;
            WBs_ACK_o <= access_c;
            if (rd_c) WBs_DAT_o <= rdata_c;
            if (wr_c) begin
                case (offset_c)
                    REG_ENABLE: enable <= NUM_SRC'((32'(enable) & ~lane_mask_c) | wdata_c);
                    REG_MODE:   mode   <= NUM_SRC'((32'(mode) & ~lane_mask_c) | wdata_c);
                    REG_ROUTE:  route  <= RTW'((32'(route) & ~lane_mask_c) | wdata_c);
                    default:    ;
                endcase
            end
        end
    end

endmodule
